// File: rtl/rv32_pkg.sv
// Shared RV32 datapath types.
package rv32;
    typedef logic [31:0] word;
endpackage

// File: rtl/saratoga_pkg.sv
// Project-wide defaults and shared types for the ROM arbiter.
package saratoga;
    localparam int DEFAULT_ROM_ADDR_WIDTH  = 10;
    localparam int DEFAULT_ROM_ARB_NUM_REQ = 2;
    localparam int ROM_ARB_MAX_REQ         = 8;

    // Requester index wide enough for the largest supported configuration.
    typedef logic [$clog2(ROM_ARB_MAX_REQ)-1:0] rom_arb_id_t;
endpackage

// File: rtl/rom_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_req
);
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = IW'(idx);
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one registered-read ROM port with one read in flight.
// Define ROM_ARB_PERF_EN to add per-requester grant and stall counters.
module rom_arbiter
    import saratoga::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ROM_ADDR_WIDTH,
    parameter int NUM_REQ    = DEFAULT_ROM_ARB_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output rv32::word                     rsp_data,
    output logic                          rom_rd_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  rv32::word                     rom_rd_data
`ifdef ROM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]         perf_grants,
    output logic [31:0]                   perf_stall
`endif
);
    localparam int IDW = $clog2(NUM_REQ);

    logic           r_pend;
    logic [IDW-1:0] r_pend_id;
    logic [IDW-1:0] r_rr_ptr;

    logic           w_free;
    logic           w_issue;
    logic           w_any_req;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_next_ptr;
    logic [IDW-1:0] w_addr_sel;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .grant   (w_grant),
        .any_req (w_any_req)
    );

    // The ROM holds rd_data while rd_en is low, so a stalled response needs no
    // local buffer: simply refuse new issues until it is consumed.
    assign w_free     = !r_pend || rsp_ready[r_pend_id];
    assign w_issue    = rst_n && w_free && w_any_req;
    assign w_next_ptr = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_addr_sel = rst_n ? w_grant : '0;

    assign rom_rd_en = w_issue;
    assign rom_addr  = req_addr[int'(w_addr_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign rsp_data  = rom_rd_data;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_ready[gi] = w_issue && (w_grant == IDW'(gi));
        assign rsp_valid[gi] = r_pend && (r_pend_id == IDW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 1'b0;
            r_pend_id <= '0;
            r_rr_ptr  <= '0;
        end else if (w_issue) begin
            r_pend    <= 1'b1;
            r_pend_id <= w_grant;
            r_rr_ptr  <= w_next_ptr;
        end else if (w_free) begin
            r_pend    <= 1'b0;
        end
    end

`ifdef ROM_ARB_PERF_EN
    logic [31:0] r_perf_grants [NUM_REQ];
    logic [31:0] r_perf_stall;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_perf_grants[gi] <= '0;
            end else if (req_ready[gi]) begin
                r_perf_grants[gi] <= r_perf_grants[gi] + 32'd1;
            end
        end
        assign perf_grants[gi*32 +: 32] = r_perf_grants[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
        end else if (r_pend && !rsp_ready[r_pend_id]) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
    assign perf_stall = r_perf_stall;
`endif
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed plus randomized bench for rom_arbiter against a transaction-level model.
module tb_rom_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 10;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] rsp_ready;
    logic [31:0]     rsp_data;
    logic            rom_rd_en;
    logic [AW-1:0]   rom_addr;
    logic [31:0]     rom_rd_data;
`ifdef ROM_ARB_PERF_EN
    logic [NREQ*32-1:0] perf_grants;
    logic [31:0]        perf_stall;
`endif

    rom_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rom_rd_en   (rom_rd_en),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data)
`ifdef ROM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with one-cycle registered read that holds its output when idle
    logic [31:0] rom_mem [1 << AW];
    always @(posedge clk) begin
        if (rom_rd_en) rom_rd_data <= rom_mem[rom_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one outstanding transaction plus priority pointer
    bit          m_pend;
    int          m_id;
    logic [AW-1:0] m_addr;
    int          m_ptr;
    int          m_grants [NREQ];
    int          m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_id   = 0;
        m_addr = '0;
        m_ptr  = 0;
        m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_grants[i] = 0;
    endtask

    // One clock of traffic: apply inputs, compare against the model, advance it.
    task automatic step(input logic [NREQ-1:0] v, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [NREQ-1:0] rr,
                        output logic [NREQ-1:0] gnt);
        logic [AW-1:0]   a [NREQ];
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        bit free;
        bit issue;
        int g;
        @(negedge clk);
        req_valid = v;
        req_addr  = {a1, a0};
        rsp_ready = rr;
        #1;
        a[0] = a0;
        a[1] = a1;
        free  = !m_pend || rr[m_id];
        issue = free && (v != '0);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_rdy = '0;
        if (issue) exp_rdy[g] = 1'b1;
        exp_rsp = '0;
        if (m_pend) exp_rsp[m_id] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rom_rd_en", 64'(rom_rd_en), 64'(issue));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (issue) chk("rom_addr", 64'(rom_addr), 64'(a[g]));
        if (m_pend) chk("rsp_data", 64'(rsp_data), 64'(rom_mem[m_addr]));
        gnt = exp_rdy;
        if (m_pend && !rr[m_id]) m_stall++;
        if (issue) begin
            m_pend = 1;
            m_id   = g;
            m_addr = a[g];
            m_ptr  = (g + 1) % NREQ;
            m_grants[g]++;
        end else if (free) begin
            m_pend = 0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] rr;
        bit              hold_v [NREQ];
        logic [AW-1:0]   hold_a [NREQ];

        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = $urandom;
        rom_mem[10'h010] = 32'hDEADBEEF;
        model_reset();

        // Reset with both requesters asking
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_addr  = {10'd7, 10'd5};
        rsp_ready = 2'b11;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rom_rd_en", 64'(rom_rd_en), 64'(0));
        chk("rst_rom_addr",  64'(rom_addr),  64'(5));
`ifdef ROM_ARB_PERF_EN
        chk("rst_perf_stall", 64'(perf_stall), 64'(0));
`endif
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        step(2'b11, 10'h001, 10'h002, 2'b11, g);
        chk("first_grant", 64'(g), 64'(2'b01));

        // Single read of a known word by requester 1
        step(2'b10, 10'h000, 10'h010, 2'b11, g);
        chk("single_grant", 64'(g), 64'(2'b10));
        step(2'b00, 10'h000, 10'h000, 2'b11, g);
        chk("single_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("single_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));

        // Continuous requests alternate between requesters
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 10'($urandom), 10'($urandom), 2'b11, g);
            chk("rr_alternate", 64'(g), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
        end
        step(2'b00, 10'h000, 10'h000, 2'b11, g);

        // Backpressure on requester 0's response blocks requester 1
        step(2'b01, 10'h020, 10'h000, 2'b11, g);
        chk("bp_first_grant", 64'(g), 64'(2'b01));
        for (int k = 0; k < 5; k++) begin
            step(2'b10, 10'h000, 10'h030, 2'b10, g);
            chk("bp_rd_en", 64'(rom_rd_en), 64'(0));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_data_stable", 64'(rsp_data), 64'(rom_mem[10'h020]));
        end
        step(2'b10, 10'h000, 10'h030, 2'b11, g);
        chk("bp_release_grant", 64'(g), 64'(2'b10));
        step(2'b00, 10'h000, 10'h000, 2'b11, g);
        chk("bp_second_data", 64'(rsp_data), 64'(rom_mem[10'h030]));

        // Reset the cycle after a grant drops the read
        step(2'b01, 10'h040, 10'h000, 2'b11, g);
        chk("mid_grant", 64'(g), 64'(2'b01));
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rom_rd_en", 64'(rom_rd_en), 64'(0));
        @(negedge clk);
        #1;
        chk("mid_rsp_valid_hold", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;
        model_reset();
        step(2'b00, 10'h000, 10'h000, 2'b11, g);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        step(2'b01, 10'h040, 10'h000, 2'b11, g);
        step(2'b00, 10'h000, 10'h000, 2'b11, g);
        chk("reissue_data", 64'(rsp_data), 64'(rom_mem[10'h040]));

        // Randomized traffic; requesters hold valid/address until accepted
        for (int i = 0; i < NREQ; i++) begin
            hold_v[i] = 0;
            hold_a[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hold_v[i]) begin
                    hold_v[i] = ($urandom_range(0, 2) != 0);
                    hold_a[i] = AW'($urandom);
                end
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            step({hold_v[1], hold_v[0]}, hold_a[0], hold_a[1], rr, g);
            for (int i = 0; i < NREQ; i++) if (g[i]) hold_v[i] = 0;
        end
        step(2'b00, 10'h000, 10'h000, 2'b11, g);

`ifdef ROM_ARB_PERF_EN
        chk("perf_grants0", 64'(perf_grants[31:0]),  64'(m_grants[0]));
        chk("perf_grants1", 64'(perf_grants[63:32]), 64'(m_grants[1]));
        chk("perf_stall",   64'(perf_stall),         64'(m_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
